// File: rtl/switch_debounce.sv
// Debounces a raw asynchronous switch input into a clean level on sysclk.
// Also produces one-cycle rise/fall pulses and a busy flag while a change is being timed.
module switch_debounce #(
    parameter int   N         = 8,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic         sysclk,
    input  logic         reset,
    input  logic [N-1:0] max_value,
    input  logic         signal_i,
    output logic         signal_o,
    output logic         rise_o,
    output logic         fall_o,
    output logic         busy_o
);

    logic         sync1_q, sync2_q;
    logic [N-1:0] cnt_q, cnt_d;
    logic         sig_q, sig_d;
    logic         sig_dly_q;

    // NOTE: every next-state signal gets a default before any branch, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        sig_d = sig_q;
        if (sync2_q == sig_q) begin
            cnt_d = '0;
        end else if (cnt_q >= max_value) begin
            sig_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so that all flops update together.
    // NOTE: the synchroniser flops are reset as well, so the filter never sees X out of reset.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync1_q   <= RESET_VAL;
            sync2_q   <= RESET_VAL;
            cnt_q     <= '0;
            sig_q     <= RESET_VAL;
            sig_dly_q <= RESET_VAL;
        end else begin
            sync1_q   <= signal_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            sig_q     <= sig_d;
            sig_dly_q <= sig_q;
        end
    end

    // Edge pulses compare the level with its delayed copy, so they last exactly one cycle.
    assign signal_o = sig_q;
    assign rise_o   = sig_q & ~sig_dly_q;
    assign fall_o   = ~sig_q & sig_dly_q;
    assign busy_o   = (cnt_q != '0);

endmodule

// File: tb/tb_switch_debounce.sv
// Directed testbench for switch_debounce with N=8 and RESET_VAL=0.
// Cycle counts are taken from the first sysclk edge that can capture the new input level.
module tb_switch_debounce;

    logic       sysclk;
    logic       reset;
    logic [7:0] max_value;
    logic       signal_i;
    logic       signal_o;
    logic       rise_o;
    logic       fall_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    int toggles = 0;
    int rises   = 0;
    int falls   = 0;
    logic prev_o = 1'b0;

    switch_debounce #(.N(8), .RESET_VAL(1'b0)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .max_value (max_value),
        .signal_i  (signal_i),
        .signal_o  (signal_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .busy_o    (busy_o)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Observes the outputs away from the active edge to count level changes and pulses.
    always @(negedge sysclk) begin
        if (signal_o !== prev_o) toggles <= toggles + 1;
        if (rise_o) rises <= rises + 1;
        if (fall_o) falls <= falls + 1;
        prev_o <= signal_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    int t0, r0, f0;
    logic busy_seen;

    initial begin
        reset     = 1'b1;
        signal_i  = 1'b1;
        max_value = 8'h0F;

        // 1: reset state, then clean rising step with signal_i already high
        tick(3);
        check("rst_signal_o", {31'b0, signal_o}, 32'd0);
        check("rst_rise_o",   {31'b0, rise_o},   32'd0);
        check("rst_fall_o",   {31'b0, fall_o},   32'd0);
        check("rst_busy_o",   {31'b0, busy_o},   32'd0);
        reset = 1'b0;
        tick(17);
        check("step_cyc17_low", {31'b0, signal_o}, 32'd0);
        tick(1);
        check("step_cyc18_high", {31'b0, signal_o}, 32'd1);
        check("step_rise_pulse", {31'b0, rise_o},   32'd1);
        tick(1);
        check("step_rise_end",   {31'b0, rise_o},   32'd0);

        // 2: bounces then settle low
        tick(2);
        t0 = toggles; r0 = rises; f0 = falls;
        for (int i = 0; i < 20; i++) begin
            #2 signal_i = 1'($urandom_range(0, 1));
        end
        #2 signal_i = 1'b0;
        tick(18);
        check("bounce_settled_low", {31'b0, signal_o}, 32'd0);
        tick(2);
        check("bounce_toggles", toggles - t0, 32'd1);
        check("bounce_falls",   falls - f0,   32'd1);
        check("bounce_rises",   rises - r0,   32'd0);

        // 3: 10-cycle pulse is rejected
        t0 = toggles;
        busy_seen = 1'b0;
        signal_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            busy_seen |= busy_o;
        end
        signal_i = 1'b0;
        tick(4);
        check("glitch_busy_seen",  {31'b0, busy_seen}, 32'd1);
        check("glitch_busy_clear", {31'b0, busy_o},    32'd0);
        check("glitch_signal_o",   {31'b0, signal_o},  32'd0);
        check("glitch_toggles",    toggles - t0,       32'd0);

        // 4: threshold extremes
        max_value = 8'h00;
        signal_i  = 1'b1;
        tick(2);
        check("max0_cyc2_low",  {31'b0, signal_o}, 32'd0);
        tick(1);
        check("max0_cyc3_high", {31'b0, signal_o}, 32'd1);
        signal_i = 1'b0;
        tick(5);
        check("max0_back_low",  {31'b0, signal_o}, 32'd0);
        max_value = 8'hFF;
        signal_i  = 1'b1;
        tick(257);
        check("maxff_cyc257_low", {31'b0, signal_o}, 32'd0);
        check("maxff_busy",       {31'b0, busy_o},   32'd1);
        tick(1);
        check("maxff_cyc258_high", {31'b0, signal_o}, 32'd1);

        // 5: reset in the middle of a count discards the pending change
        reset     = 1'b1;
        signal_i  = 1'b0;
        max_value = 8'h0F;
        tick(2);
        reset = 1'b0;
        tick(3);
        signal_i = 1'b1;
        tick(12);
        check("midrst_busy_before", {31'b0, busy_o},   32'd1);
        check("midrst_low_before",  {31'b0, signal_o}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("midrst_signal_o", {31'b0, signal_o}, 32'd0);
        check("midrst_busy_o",   {31'b0, busy_o},   32'd0);
        tick(1);
        reset = 1'b0;
        tick(17);
        check("midrst_cyc17_low",  {31'b0, signal_o}, 32'd0);
        tick(1);
        check("midrst_cyc18_high", {31'b0, signal_o}, 32'd1);

        // 6: lowering the threshold mid-count takes effect on the next edge
        tick(2);
        signal_i = 1'b0;
        tick(10);
        check("lower_before", {31'b0, signal_o}, 32'd1);
        max_value = 8'h03;
        tick(1);
        check("lower_after",  {31'b0, signal_o}, 32'd0);
        check("lower_fall",   {31'b0, fall_o},   32'd1);
        tick(1);
        check("lower_fall_end", {31'b0, fall_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
